// File: rtl/cpu_parameters.sv
// cpu_parameters: core-wide constants and the result-entry record shared
// between the execute units and the write-back stage.
//   xlen        - architectural data width
//   wb_entry_t  - {valid, rd, data} result entry
package cpu_parameters;
   localparam int xlen = 32;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd;
      logic [xlen-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: types local to the write-back stage.
//   grant_e - which source (if any) the arbiter accepted this cycle
package wb_stage_pkg;
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_ALU  = 2'd1,
      GRANT_LSU  = 2'd2
   } grant_e;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: execute-side and register-file/PC-side signals of the
// write-back stage.
// Handshake: a source presents an entry with its valid(s) high; the entry is
// taken at the rising edge where the matching ok is high. While ok is low the
// source must hold the entry stable. There is no backpressure on the outputs.
// Modports:
//   master - execute units / PC control side (drives entries, sees results)
//   slave  - wb_stage
// Optional: WB_RETIRE_COUNT_EN adds the 64-bit retired counter output.
interface wb_stage_if #(
   parameter int XLEN = cpu_parameters::xlen
);
   logic            alu_result_valid;
   logic [XLEN-1:0] alu_result;
   logic [4:0]      alu_rd;
   logic            alu_target_valid;
   logic [XLEN-1:0] alu_target;
   logic            alu_ok;
   logic            lsu_valid;
   logic [XLEN-1:0] lsu_data;
   logic [4:0]      lsu_rd;
   logic            lsu_ok;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            pc_target_valid;
   logic [XLEN-1:0] pc_target;
   logic            flush;
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0]     retired;
`endif

   modport master (
      output alu_result_valid, alu_result, alu_rd, alu_target_valid, alu_target,
      output lsu_valid, lsu_data, lsu_rd,
      input  alu_ok, lsu_ok, rf_we, rf_waddr, rf_wdata,
      input  pc_target_valid, pc_target, flush
`ifdef WB_RETIRE_COUNT_EN
      , input retired
`endif
   );

   modport slave (
      input  alu_result_valid, alu_result, alu_rd, alu_target_valid, alu_target,
      input  lsu_valid, lsu_data, lsu_rd,
      output alu_ok, lsu_ok, rf_we, rf_waddr, rf_wdata,
      output pc_target_valid, pc_target, flush
`ifdef WB_RETIRE_COUNT_EN
      , output retired
`endif
   );
endinterface

// File: rtl/wb_stage_arbiter.sv
// wb_arbiter: two-way round-robin grant between the ALU and LSU entries.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   alu_present   - ALU entry present (result and/or redirect)
//   lsu_present   - LSU load result present
//   flush         - registered flush; blocks all grants while high
//   alu_ok/lsu_ok - combinational accept strobes
//   grant         - encoded grant for the datapath select
module wb_arbiter
   import wb_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   alu_present,
   input  logic   lsu_present,
   input  logic   flush,
   output logic   alu_ok,
   output logic   lsu_ok,
   output grant_e grant
);
   // 1 when the most recent grant went to the LSU; the other source wins ties.
   logic last_lsu;

   always_comb begin
      alu_ok = 1'b0;
      lsu_ok = 1'b0;
      grant  = GRANT_NONE;
      if (!flush) begin
         if (lsu_present && (!alu_present || !last_lsu)) begin
            lsu_ok = 1'b1;
            grant  = GRANT_LSU;
         end else if (alu_present) begin
            alu_ok = 1'b1;
            grant  = GRANT_ALU;
         end
      end
   end

   // Only real grants move the round-robin bit; flush cycles leave it alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_lsu <= 1'b0;
      end else if (grant == GRANT_LSU) begin
         last_lsu <= 1'b1;
      end else if (grant == GRANT_ALU) begin
         last_lsu <= 1'b0;
      end
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Arbitrates ALU and LSU results onto the single
// register-file write port and turns taken ALU branches/jumps into a
// registered PC redirect with a one-cycle flush pulse.
// Ports:
//   clk   - core clock
//   rst_n - synchronous active-low reset
//   bus   - wb_stage_if.slave (entries in, ok strobes, rf write, redirect)
// Optional: define WB_RETIRE_COUNT_EN for the 64-bit retired-entry counter.
module wb_stage
   import cpu_parameters::*;
   import wb_stage_pkg::*;
#(
   parameter int XLEN = cpu_parameters::xlen
) (
   input logic         clk,
   input logic         rst_n,
   wb_stage_if.slave   bus
);
   logic      alu_present;
   grant_e    grant;
   wb_entry_t sel;

   assign alu_present = bus.alu_result_valid | bus.alu_target_valid;

   wb_arbiter u_arbiter (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_present (alu_present),
      .lsu_present (bus.lsu_valid),
      .flush       (bus.flush),
      .alu_ok      (bus.alu_ok),
      .lsu_ok      (bus.lsu_ok),
      .grant       (grant)
   );

   // Winning entry; valid means "carries a register result" (a bare branch
   // has none).
   always_comb begin
      sel = '0;
      case (grant)
         GRANT_ALU: begin
            sel.valid = bus.alu_result_valid;
            sel.rd    = bus.alu_rd;
            sel.data  = bus.alu_result;
         end
         GRANT_LSU: begin
            sel.valid = 1'b1;
            sel.rd    = bus.lsu_rd;
            sel.data  = bus.lsu_data;
         end
         default: ;
      endcase
   end

   // Write port and redirect. Address/data/target hold between writes;
   // the strobes are single-cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rf_we           <= 1'b0;
         bus.rf_waddr        <= '0;
         bus.rf_wdata        <= '0;
         bus.pc_target_valid <= 1'b0;
         bus.pc_target       <= '0;
         bus.flush           <= 1'b0;
      end else begin
         bus.rf_we           <= 1'b0;
         bus.pc_target_valid <= 1'b0;
         bus.flush           <= 1'b0;
         if (sel.valid) begin
            // x0 is hardwired: the entry retires but nothing is written.
            bus.rf_we    <= (sel.rd != 5'd0);
            bus.rf_waddr <= sel.rd;
            bus.rf_wdata <= sel.data;
         end
         if (grant == GRANT_ALU && bus.alu_target_valid) begin
            bus.pc_target_valid <= 1'b1;
            bus.pc_target       <= bus.alu_target;
            bus.flush           <= 1'b1;
         end
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   // Every accepted entry retires, including bare branches and x0 writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.retired <= '0;
      end else if (grant != GRANT_NONE) begin
         bus.retired <= bus.retired + 64'd1;
      end
   end
`endif
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
   import cpu_parameters::*;

   localparam int XLEN = cpu_parameters::xlen;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(XLEN)) bus ();

   wb_stage #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic            alu_rv;
      logic            alu_tv;
      logic [4:0]      alu_rd;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] alu_tgt;
      logic            lsu_v;
      logic [4:0]      lsu_rd;
      logic [XLEN-1:0] lsu_data;
      // expected: ok during the drive cycle, registered outputs after the edge
      logic            e_aok;
      logic            e_lok;
      logic            e_we;
      logic [4:0]      e_waddr;
      logic [XLEN-1:0] e_wdata;
      logic            e_pctv;
      logic [XLEN-1:0] e_pc;
      logic            e_flush;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   int checks;
   int errors;
   logic [63:0] exp_retired;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.alu_result_valid = 1'b0;
      bus.alu_target_valid = 1'b0;
      bus.alu_rd           = '0;
      bus.alu_result       = '0;
      bus.alu_target       = '0;
      bus.lsu_valid        = 1'b0;
      bus.lsu_rd           = '0;
      bus.lsu_data         = '0;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.alu_result_valid = v.alu_rv;
      bus.alu_target_valid = v.alu_tv;
      bus.alu_rd           = v.alu_rd;
      bus.alu_result       = v.alu_res;
      bus.alu_target       = v.alu_tgt;
      bus.lsu_valid        = v.lsu_v;
      bus.lsu_rd           = v.lsu_rd;
      bus.lsu_data         = v.lsu_data;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " rf_we"},           64'(bus.rf_we),           64'd0);
      chk({tag, " rf_waddr"},        64'(bus.rf_waddr),        64'd0);
      chk({tag, " rf_wdata"},        64'(bus.rf_wdata),        64'd0);
      chk({tag, " pc_target_valid"}, 64'(bus.pc_target_valid), 64'd0);
      chk({tag, " pc_target"},       64'(bus.pc_target),       64'd0);
      chk({tag, " flush"},           64'(bus.flush),           64'd0);
`ifdef WB_RETIRE_COUNT_EN
      chk({tag, " retired"},         bus.retired,              64'd0);
`endif
   endtask

   // ---------------- test ----------------
   initial begin
      checks      = 0;
      errors      = 0;
      exp_retired = 64'd0;

      //           rv  tv  rd  res        tgt        lv  lrd lda        aok lok we waddr wdata      pctv pc         flush
      // idle after reset
      vecs[0]  = '{0, 0, 5'd0, 32'h0,     32'h0,     0, 5'd0, 32'h0,     0, 0, 0, 5'd0, 32'h0,     0, 32'h0,     0};
      // ALU result rd=5
      vecs[1]  = '{1, 0, 5'd5, 32'h1234,  32'h0,     0, 5'd0, 32'h0,     1, 0, 1, 5'd5, 32'h1234,  0, 32'h0,     0};
      // both present x4: LSU, ALU, LSU, ALU
      vecs[2]  = '{1, 0, 5'd1, 32'hA1,    32'h0,     1, 5'd2, 32'hB2,    0, 1, 1, 5'd2, 32'hB2,    0, 32'h0,     0};
      vecs[3]  = '{1, 0, 5'd1, 32'hA1,    32'h0,     1, 5'd2, 32'hB2,    1, 0, 1, 5'd1, 32'hA1,    0, 32'h0,     0};
      vecs[4]  = '{1, 0, 5'd1, 32'hA1,    32'h0,     1, 5'd2, 32'hB2,    0, 1, 1, 5'd2, 32'hB2,    0, 32'h0,     0};
      vecs[5]  = '{1, 0, 5'd1, 32'hA1,    32'h0,     1, 5'd2, 32'hB2,    1, 0, 1, 5'd1, 32'hA1,    0, 32'h0,     0};
      // jump with result: redirect to 0x80 and write x1=0x44
      vecs[6]  = '{1, 1, 5'd1, 32'h44,    32'h80,    0, 5'd0, 32'h0,     1, 0, 1, 5'd1, 32'h44,    1, 32'h80,    1};
      // flush cycle: both present, nothing accepted, last_lsu stays 0
      vecs[7]  = '{1, 0, 5'd3, 32'h55,    32'h0,     1, 5'd4, 32'h66,    0, 0, 0, 5'd1, 32'h44,    0, 32'h80,    0};
      // tie after flush: LSU still wins
      vecs[8]  = '{1, 0, 5'd3, 32'h55,    32'h0,     1, 5'd4, 32'h66,    0, 1, 1, 5'd4, 32'h66,    0, 32'h80,    0};
      // LSU load to x0: accepted, no write
      vecs[9]  = '{0, 0, 5'd0, 32'h0,     32'h0,     1, 5'd0, 32'hFFFF,  0, 1, 0, 5'd0, 32'hFFFF,  0, 32'h80,    0};
      // bare branch vs LSU tie, last was LSU -> ALU wins, no register write
      vecs[10] = '{0, 1, 5'd0, 32'h0,     32'h100,   1, 5'd7, 32'h77,    1, 0, 0, 5'd0, 32'hFFFF,  1, 32'h100,   1};
      // flush cycle: LSU blocked
      vecs[11] = '{0, 0, 5'd0, 32'h0,     32'h0,     1, 5'd7, 32'h77,    0, 0, 0, 5'd0, 32'hFFFF,  0, 32'h100,   0};
      // LSU now accepted
      vecs[12] = '{0, 0, 5'd0, 32'h0,     32'h0,     1, 5'd7, 32'h77,    0, 1, 1, 5'd7, 32'h77,    0, 32'h100,   0};

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive_vec(vecs[i]);
         #1;
         chk($sformatf("v%0d alu_ok", i), 64'(bus.alu_ok), 64'(vecs[i].e_aok));
         chk($sformatf("v%0d lsu_ok", i), 64'(bus.lsu_ok), 64'(vecs[i].e_lok));
         if (vecs[i].e_aok || vecs[i].e_lok) exp_retired = exp_retired + 64'd1;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d rf_we", i),           64'(bus.rf_we),           64'(vecs[i].e_we));
         chk($sformatf("v%0d rf_waddr", i),        64'(bus.rf_waddr),        64'(vecs[i].e_waddr));
         chk($sformatf("v%0d rf_wdata", i),        64'(bus.rf_wdata),        64'(vecs[i].e_wdata));
         chk($sformatf("v%0d pc_target_valid", i), 64'(bus.pc_target_valid), 64'(vecs[i].e_pctv));
         chk($sformatf("v%0d pc_target", i),       64'(bus.pc_target),       64'(vecs[i].e_pc));
         chk($sformatf("v%0d flush", i),           64'(bus.flush),           64'(vecs[i].e_flush));
`ifdef WB_RETIRE_COUNT_EN
         chk($sformatf("v%0d retired", i),         bus.retired,              exp_retired);
`endif
      end

      // Reset asserted while flush is high: redirect and flush dropped.
      @(negedge clk);
      drive_idle();
      bus.alu_result_valid = 1'b1;
      bus.alu_target_valid = 1'b1;
      bus.alu_rd           = 5'd9;
      bus.alu_result       = 32'h99;
      bus.alu_target       = 32'h200;
      @(posedge clk);
      #1;
      chk("mid flush", 64'(bus.flush), 64'd1);
      chk("mid pc_target", 64'(bus.pc_target), 64'h200);
      chk("mid rf_waddr", 64'(bus.rf_waddr), 64'd9);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("mid reset");

      // After reset the LSU wins the first tie again.
      @(negedge clk);
      rst_n = 1'b1;
      bus.alu_result_valid = 1'b1;
      bus.alu_rd           = 5'd10;
      bus.alu_result       = 32'hAA;
      bus.lsu_valid        = 1'b1;
      bus.lsu_rd           = 5'd11;
      bus.lsu_data         = 32'hBB;
      #1;
      chk("post reset alu_ok", 64'(bus.alu_ok), 64'd0);
      chk("post reset lsu_ok", 64'(bus.lsu_ok), 64'd1);
      @(posedge clk);
      #1;
      chk("post reset rf_waddr", 64'(bus.rf_waddr), 64'd11);
      chk("post reset rf_wdata", 64'(bus.rf_wdata), 64'hBB);
`ifdef WB_RETIRE_COUNT_EN
      chk("post reset retired", bus.retired, 64'd1);
`endif
      @(negedge clk);
      drive_idle();

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
